ex_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the pipelined EX stage. It supersedes the single-cycle combinational `busA*srcB` path.
- Iterative shift-add multiply and restoring divide, signed and unsigned.
- Full-width product (low/high half selectable), quotient and remainder.
- valid/ready handshake so the pipeline control can stall EX while the unit is busy, plus a flush input for branch squash.

---
 rtl/ex_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 30 +++
 rtl/ex_muldiv.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package ex_pkg;

    typedef enum logic [1:0] {
        OP_MUL_LO = 2'b00,
        OP_MUL_HI = 2'b01,
        OP_DIV    = 2'b10,
        OP_REM    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    localparam int MAX_WIDTH = 64;

    // Quotient returned on divide-by-zero; sliced to the unit width.
    localparam logic [MAX_WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd};
        qbit     = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        // Divide: high half is the partial remainder, low half shifts dividend
        // bits out and leaves a zero slot for the quotient bit.
        if (is_div) begin
            qbit     = ~diff[WIDTH];
            acc_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle signed/unsigned multiply/divide unit with valid/ready handshake and flush.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             dz,
    output logic             busy
);

    state_e             state, state_n;
    op_e                op_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] acc, acc_next, acc_upd, prod;
    logic [WIDTH-1:0]   opnd, a_mag, b_mag, quot, rem, result;
    logic [CNT_W-1:0]   cnt;
    logic               qbit, is_div, accept, start, dz_hit, finish;
    logic               sa, sb, div_req, last;

    assign sa      = is_signed & src_a[WIDTH-1];
    assign sb      = is_signed & src_b[WIDTH-1];
    assign a_mag   = sa ? -src_a : src_a;
    assign b_mag   = sb ? -src_b : src_b;
    assign div_req = (op == OP_DIV) || (op == OP_REM);
    assign is_div  = (op_q == OP_DIV) || (op_q == OP_REM);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (is_div),
        .acc_next (acc_next),
        .qbit     (qbit)
    );

    // Final iteration's value feeds sign correction directly so the result
    // registers on the WIDTH-th CALC edge.
    always_comb begin
        acc_upd = acc_next | {{(2*WIDTH-1){1'b0}}, qbit};
        prod    = sign_q ? -acc_upd : acc_upd;
        quot    = sign_q ? -acc_upd[WIDTH-1:0] : acc_upd[WIDTH-1:0];
        rem     = sign_q ? -acc_upd[2*WIDTH-1:WIDTH] : acc_upd[2*WIDTH-1:WIDTH];
        result  = '0;
        case (op_q)
            OP_MUL_LO: result = prod[WIDTH-1:0];
            OP_MUL_HI: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV:    result = quot;
            OP_REM:    result = rem;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        dz_hit  = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if ((state == S_DONE) && out_ready) state_n = S_IDLE;
                if (accept) begin
                    if (div_req && (src_b == '0)) begin
                        state_n = S_DONE;
                        dz_hit  = 1'b1;
                    end else begin
                        state_n = S_CALC;
                        start   = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (last) begin
                    state_n = S_DONE;
                    finish  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Flush wins over everything, including a result landing this edge.
        if (flush) begin
            state_n = S_IDLE;
            start   = 1'b0;
            dz_hit  = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            op_q   <= OP_MUL_LO;
            sign_q <= 1'b0;
            res    <= '0;
            dz     <= 1'b0;
        end else begin
            if (start) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
                cnt  <= '0;
            end else if (state == S_CALC) begin
                acc <= acc_upd;
                cnt <= cnt + CNT_W'(1);
            end
            if (start || dz_hit) begin
                op_q   <= op_e'(op);
                sign_q <= (op == OP_REM) ? sa : (sa ^ sb);
            end
            if (dz_hit) begin
                res <= (op == OP_DIV) ? DZ_QUOT[WIDTH-1:0] : src_a;
                dz  <= 1'b1;
            end else if (finish) begin
                res <= result;
                dz  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv at WIDTH=8 against an arithmetic reference model.
module tb_ex_muldiv;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic         is_signed;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         dz;
    logic         busy;

    int errors = 0;
    int checks = 0;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_signed (is_signed),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .dz        (dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; SV division truncates toward zero
    // and % takes the dividend's sign.
    function automatic void model(input logic [1:0] o, input logic s,
                                  input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic d);
        longint av, bv, t;
        av = s ? longint'($signed(a)) : longint'(a);
        bv = s ? longint'($signed(b)) : longint'(b);
        d  = 1'b0;
        r  = 8'h00;
        t  = 0;
        case (o)
            2'd0: begin t = av * bv; r = t[7:0];  end
            2'd1: begin t = av * bv; r = t[15:8]; end
            2'd2: if (b == 8'h00) begin r = 8'hFF; d = 1'b1; end
                  else begin t = av / bv; r = t[7:0]; end
            default: if (b == 8'h00) begin r = a; d = 1'b1; end
                     else begin t = av % bv; r = t[7:0]; end
        endcase
    endfunction

    // Drive one request, scramble inputs after accept, wait for the result
    // (lat = edges after the accept edge), then consume it.
    task automatic run_op(input logic [1:0] o, input logic s, input logic [7:0] a,
                          input logic [7:0] b, output logic [7:0] r, output logic d,
                          output int lat);
        int n;
        op = o; is_signed = s; src_a = a; src_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); is_signed = 1'($urandom);
        src_a = 8'($urandom); src_b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        r = res; d = dz;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; is_signed = 1'b0; src_a = '0; src_b = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (res !== 8'h00)      begin errors++; $display("FAIL reset_res got=%h want=00", res); end
        checks++; if (dz !== 1'b0)        begin errors++; $display("FAIL reset_dz got=%b want=0", dz); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [1:0] t_op [11] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
        logic       t_s  [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] t_a  [11] = '{8'hFB, 8'hFB, 8'hFB, 8'hF9, 8'hF9, 8'hF9, 8'hF9, 8'h25, 8'h25, 8'h80, 8'h80};
        logic [7:0] t_b  [11] = '{8'h03, 8'h03, 8'h03, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] t_r  [11] = '{8'hF1, 8'hFF, 8'h02, 8'hFD, 8'hFF, 8'h7C, 8'h01, 8'hFF, 8'h25, 8'h80, 8'h00};
        logic       t_dz [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] r;
        logic       d;
        int         lat;
        for (int i = 0; i < 11; i++) begin
            run_op(t_op[i], t_s[i], t_a[i], t_b[i], r, d, lat);
            checks++; if (r !== t_r[i])  begin errors++; $display("FAIL dir%0d_res got=%h want=%h", i, r, t_r[i]); end
            checks++; if (d !== t_dz[i]) begin errors++; $display("FAIL dir%0d_dz got=%b want=%b", i, d, t_dz[i]); end
            checks++; if (lat != (t_dz[i] ? 0 : W))
                begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_dz[i] ? 0 : W); end
        end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic       s, d, ed;
        logic [7:0] a, b, r, er;
        int         lat;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom); s = 1'($urandom); a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if (i % 10 == 3) begin a = 8'h80; b = 8'hFF; end
            model(o, s, a, b, er, ed);
            run_op(o, s, a, b, r, d, lat);
            checks++; if (r !== er) begin errors++; $display("FAIL rnd%0d_res op=%0d s=%b a=%h b=%h got=%h want=%h", i, o, s, a, b, r, er); end
            checks++; if (d !== ed) begin errors++; $display("FAIL rnd%0d_dz got=%b want=%b", i, d, ed); end
            checks++; if (lat != (ed ? 0 : W)) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ed ? 0 : W); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1, e2;
        logic       d1, d2;
        int         lat;
        model(2'd0, 1'b1, 8'hFB, 8'h03, e1, d1);
        model(2'd2, 1'b0, 8'hC8, 8'h07, e2, d2);
        op = 2'd0; is_signed = 1'b1; src_a = 8'hFB; src_b = 8'h03; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != W) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, W); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d_out_valid got=%b want=1", i, out_valid); end
            checks++; if (res !== e1)         begin errors++; $display("FAIL b2b_hold%0d_res got=%h want=%h", i, res, e1); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL b2b_hold%0d_in_ready got=%b want=0", i, in_ready); end
        end
        op = 2'd2; is_signed = 1'b0; src_a = 8'hC8; src_b = 8'h07;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; src_a = 8'h00; src_b = 8'h00;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_second_accept got=v%b/b%b want=v0/b1", out_valid, busy); end
        lat = 0;
        while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != W) begin errors++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, W); end
        checks++; if (res !== e2) begin errors++; $display("FAIL b2b_second_res got=%h want=%h", res, e2); end
        checks++; if (dz !== d2)  begin errors++; $display("FAIL b2b_second_dz got=%b want=%b", dz, d2); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Runs right after back-to-back, whose last result was 0xC8/0x07 unsigned.
    task automatic test_flush();
        logic [7:0] prev;
        logic       pd;
        bit         seen;
        model(2'd2, 1'b0, 8'hC8, 8'h07, prev, pd);
        op = 2'd0; is_signed = 1'b0; src_a = 8'h11; src_b = 8'h22; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; op = 2'd1; src_a = 8'h33; src_b = 8'h44;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_result got=activity want=idle"); end
        checks++; if (res !== prev) begin errors++; $display("FAIL flush_res_kept got=%h want=%h", res, prev); end
    endtask

    task automatic test_reset_mid_calc();
        bit seen;
        op = 2'd0; is_signed = 1'b1; src_a = 8'h7F; src_b = 8'h7F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (res !== 8'h00)      begin errors++; $display("FAIL rstmid_res got=%h want=00", res); end
        checks++; if (dz !== 1'b0)        begin errors++; $display("FAIL rstmid_dz got=%b want=0", dz); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_no_partial got=activity want=idle"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
